bus_regfile: RTL and testbench
==============================

// Module: bus_regfile
// PURPOSE
//  Parametrised bank of NUM_REGS general registers sharing one tri-state data bus; 8-bit single-register generation generalised.
//  Address-selected bus read/write plus per-register increment, synchronous clear, zero flag and sticky carry.
//  Sits on the CPU internal bus; used for A/B/temp/PC-style registers; control unit drives strobes.
// PARAMETERS
//  DATA_W    8                    register and bus width (>=2)
//  NUM_REGS  4                    number of registers (>=2)
//  ADDR_W    $clog2(NUM_REGS)     select width (derived, do not override)
//  RST_VAL   '0                   reset/clear value of every register, DATA_W bits
// PORTS
//  i_clk        in     1                  system clock, rising edge
//  i_rstn       in     1                  asynchronous active-low reset
//  io_bus_data  inout  DATA_W             shared data bus
//  i_addr       in     ADDR_W             register select for all strobes
//  i_rdn        in     1                  active-low: drive selected register onto bus
//  i_wrtn       in     1                  active-low: load selected register from bus at clock edge
//  i_incn       in     1                  active-low: selected register +1 at clock edge
//  i_clrn       in     1                  active-low: selected register <= RST_VAL at clock edge
//  o_out_data   out    NUM_REGS*DATA_W    all registers, reg k at [k*DATA_W +: DATA_W], always visible
//  o_zero       out    NUM_REGS           bit k = (reg k == 0), combinational from register
//  o_carry      out    NUM_REGS           bit k sticky: set when reg k wraps on increment
//  o_err        out    1                  registered 1-cycle pulse: illegal strobe combination seen
// BEHAVIOUR
//  Reset (async, i_rstn=0): all regs <= RST_VAL, o_carry <= 0, o_err <= 0, bus released ('z); immediate, mid-op ok.
//  Read: bus = reg[i_addr] while i_rdn=0 and i_wrtn=1, combinational, zero latency; else 'z.
//  Out-of-range i_addr (>= NUM_REGS): reads release bus, writes/inc/clr ignored, o_err pulses next cycle.
//  Per-edge op on reg[i_addr], priority CLR > WR > INC; only one op per edge:
//   CLR: reg <= RST_VAL, carry <= 0.   WR: reg <= bus, carry <= 0.   INC: reg <= reg+1 mod 2^DATA_W.
//  INC from all-ones: reg <= 0, carry <= 1 (sticky until CLR/WR of that reg or reset).
//  Unselected registers hold value and carry.
//  Conflict i_rdn=0 and i_wrtn=0 same cycle: bus not driven, no write; lower-priority INC/CLR still apply; o_err=1 next cycle.
//  o_err also =1 next cycle when more than one of i_wrtn/i_incn/i_clrn low (op still resolved by priority).
//  o_err deasserts after one cycle unless condition persists.
//  Write takes value present on bus at edge; setup/hold owned by bus master.
//  Reset during any op: reset wins; no partial update.
// STRUCTURE
//  Package bus_regfile_pkg: typedef enum logic [1:0] {OP_NONE, OP_INC, OP_WR, OP_CLR} reg_op_e;
//   function decode_op(clrn, wrtn, incn) -> reg_op_e (priority encode).
//  Top: address decode, op decode, conflict/err register, tri-state driver, output flattening.
//  Sub-module reg_slice (DATA_W, RST_VAL): one register + carry flag; inputs i_clk, i_rstn, i_op, i_d; outputs o_q, o_carry.
//  Generate-loop NUM_REGS reg_slice instances; non-selected slices receive OP_NONE.
// TESTING
//  Reset with regs dirty -> all o_out_data = RST_VAL, o_carry=0, bus 'z, o_err=0, async (mid-cycle).
//  Bus 0xA5 to addr 2 wrtn=0 one edge, then rdn=0 addr 2 -> bus reads 0xA5 same cycle; other regs unchanged.
//  Write 0xFE to addr 1, incn=0 two edges -> 0xFF then 0x00, o_zero[1]=1, o_carry[1]=1; write 0x03 -> carry 0.
//  rdn=0 & wrtn=0 addr 0 -> bus 'z, reg 0 unchanged, o_err=1 exactly one cycle later for one cycle.
//  clrn=0, wrtn=0, incn=0 addr 3 holding 0x40 -> reg 3 = RST_VAL, o_err pulses; NUM_REGS=3 addr 3 -> no change, o_err.
//  Random strobe/address sweep vs reference model, DATA_W=8/NUM_REGS=4 and DATA_W=16/NUM_REGS=8, reset asserted mid-run.

Source files
------------

// File: rtl/bus_regfile_pkg.sv
// Shared types for the bus register file.
//   reg_op_e  : per-register operation applied at a clock edge
//   decode_op : priority encoder CLR > WR > INC from the active-low strobes
package bus_regfile_pkg;

    typedef enum logic [1:0] {
        OP_NONE,
        OP_INC,
        OP_WR,
        OP_CLR
    } reg_op_e;

    function automatic reg_op_e decode_op(input logic clrn,
                                          input logic wrtn,
                                          input logic incn);
        reg_op_e op;
        op = OP_NONE;
        if (!clrn) begin
            op = OP_CLR;
        end else if (!wrtn) begin
            op = OP_WR;
        end else if (!incn) begin
            op = OP_INC;
        end
        return op;
    endfunction

endpackage

// File: rtl/bus_regfile_reg_slice.sv
// One register of the bus register file plus its sticky carry flag.
// Ports:
//   i_clk    system clock, rising edge
//   i_rstn   asynchronous active-low reset
//   i_op     operation for this edge (OP_NONE when not selected)
//   i_d      load value for OP_WR (the shared bus)
//   o_q      register contents
//   o_carry  sticky wrap flag, set when an increment rolls over from all-ones
module reg_slice
    import bus_regfile_pkg::*;
#(
    parameter int                DATA_W  = 8,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  reg_op_e           i_op,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q,
    output logic              o_carry
);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_q     <= RST_VAL;
            o_carry <= 1'b0;
        end else begin
            case (i_op)
                OP_CLR: begin
                    o_q     <= RST_VAL;
                    o_carry <= 1'b0;
                end
                OP_WR: begin
                    o_q     <= i_d;
                    o_carry <= 1'b0;
                end
                OP_INC: begin
                    o_q <= o_q + DATA_W'(1);
                    // carry stays set until an explicit clear or write
                    if (&o_q) begin
                        o_carry <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/bus_regfile.sv
// Bank of NUM_REGS registers sharing one tri-state data bus.
// Ports:
//   i_clk        system clock, rising edge
//   i_rstn       asynchronous active-low reset
//   io_bus_data  shared data bus (driven only for a legal read)
//   i_addr       register select for all strobes
//   i_rdn        active-low read: selected register drives the bus
//   i_wrtn       active-low write: selected register loads the bus at the edge
//   i_incn       active-low increment of the selected register
//   i_clrn       active-low clear of the selected register to RST_VAL
//   o_out_data   all registers, reg k at [k*DATA_W +: DATA_W]
//   o_zero       bit k set when reg k is zero
//   o_carry      bit k sticky wrap flag of reg k
//   o_err        one-cycle pulse after an illegal strobe combination
module bus_regfile
    import bus_regfile_pkg::*;
#(
    parameter int                DATA_W   = 8,
    parameter int                NUM_REGS = 4,
    parameter int                ADDR_W   = $clog2(NUM_REGS),
    parameter logic [DATA_W-1:0] RST_VAL  = '0
) (
    input  logic                         i_clk,
    input  logic                         i_rstn,
    inout  wire  [DATA_W-1:0]            io_bus_data,
    input  logic [ADDR_W-1:0]            i_addr,
    input  logic                         i_rdn,
    input  logic                         i_wrtn,
    input  logic                         i_incn,
    input  logic                         i_clrn,
    output logic [NUM_REGS*DATA_W-1:0]   o_out_data,
    output logic [NUM_REGS-1:0]          o_zero,
    output logic [NUM_REGS-1:0]          o_carry,
    output logic                         o_err
);

    logic [NUM_REGS-1:0] sel;
    logic                addr_ok;
    logic                rd_wr_conflict;
    logic                wrtn_eff;
    logic                multi_op;
    logic                any_strobe;
    logic                err_d;
    logic                bus_drive;
    logic [DATA_W-1:0]   rd_data;
    reg_op_e             op_sel;
    reg_op_e             slice_op [NUM_REGS];
    logic [DATA_W-1:0]   q        [NUM_REGS];

    // One-hot select; an address past the last register selects nothing,
    // which makes every op on it a no-op and releases the bus.
    always_comb begin
        sel = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            sel[k] = (i_addr == ADDR_W'(k));
        end
    end

    assign addr_ok = |sel;

    // A simultaneous read and write is treated as a bus fight: nobody drives
    // and the write is dropped, but clear/increment still resolve normally.
    assign rd_wr_conflict = ~i_rdn & ~i_wrtn;
    assign wrtn_eff       = i_wrtn | ~i_rdn;
    assign op_sel         = decode_op(i_clrn, wrtn_eff, i_incn);

    assign multi_op   = (~i_wrtn & ~i_incn) | (~i_wrtn & ~i_clrn) | (~i_incn & ~i_clrn);
    assign any_strobe = ~(i_rdn & i_wrtn & i_incn & i_clrn);
    assign err_d      = rd_wr_conflict | multi_op | (any_strobe & ~addr_ok);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            o_err <= 1'b0;
        end else begin
            o_err <= err_d;
        end
    end

    always_comb begin
        for (int k = 0; k < NUM_REGS; k++) begin
            slice_op[k] = sel[k] ? op_sel : OP_NONE;
        end
    end

    always_comb begin
        rd_data = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (sel[k]) begin
                rd_data = q[k];
            end
        end
    end

    // Bus is released while reset is held, even with a read strobe active.
    assign bus_drive   = ~i_rdn & i_wrtn & addr_ok & i_rstn;
    assign io_bus_data = bus_drive ? rd_data : {DATA_W{1'bz}};

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_slice
        reg_slice #(
            .DATA_W  (DATA_W),
            .RST_VAL (RST_VAL)
        ) u_slice (
            .i_clk   (i_clk),
            .i_rstn  (i_rstn),
            .i_op    (slice_op[g]),
            .i_d     (io_bus_data),
            .o_q     (q[g]),
            .o_carry (o_carry[g])
        );

        assign o_out_data[g*DATA_W +: DATA_W] = q[g];
        assign o_zero[g]                      = (q[g] == '0);
    end

endmodule

// File: tb/tb_bus_regfile.sv
// Directed and randomised checks of bus_regfile in three configurations:
//   A: DATA_W=8,  NUM_REGS=4   B: DATA_W=16, NUM_REGS=8   C: DATA_W=8, NUM_REGS=3
// The buses are pulled high, so a released bus reads as all ones.
module tb_bus_regfile;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    int n_asrt = 0;
    int n_fail = 0;

    // ---------------- configuration A ----------------
    logic [1:0]  a_addr;
    logic        a_rdn, a_wrtn, a_incn, a_clrn;
    logic [31:0] a_out;
    logic [3:0]  a_zero, a_carry;
    logic        a_err;
    logic        a_drv_en;
    logic [7:0]  a_drv;
    tri1  [7:0]  a_bus;
    assign a_bus = a_drv_en ? a_drv : 8'hzz;
    logic [7:0]  ma [4];
    logic [3:0]  mca;

    bus_regfile #(.DATA_W(8), .NUM_REGS(4)) dut_a (
        .i_clk(clk), .i_rstn(rstn), .io_bus_data(a_bus), .i_addr(a_addr),
        .i_rdn(a_rdn), .i_wrtn(a_wrtn), .i_incn(a_incn), .i_clrn(a_clrn),
        .o_out_data(a_out), .o_zero(a_zero), .o_carry(a_carry), .o_err(a_err)
    );

    // ---------------- configuration B ----------------
    logic [2:0]   b_addr;
    logic         b_rdn, b_wrtn, b_incn, b_clrn;
    logic [127:0] b_out;
    logic [7:0]   b_zero, b_carry;
    logic         b_err;
    logic         b_drv_en;
    logic [15:0]  b_drv;
    tri1  [15:0]  b_bus;
    assign b_bus = b_drv_en ? b_drv : 16'hzzzz;
    logic [15:0]  mb [8];
    logic [7:0]   mcb;

    bus_regfile #(.DATA_W(16), .NUM_REGS(8)) dut_b (
        .i_clk(clk), .i_rstn(rstn), .io_bus_data(b_bus), .i_addr(b_addr),
        .i_rdn(b_rdn), .i_wrtn(b_wrtn), .i_incn(b_incn), .i_clrn(b_clrn),
        .o_out_data(b_out), .o_zero(b_zero), .o_carry(b_carry), .o_err(b_err)
    );

    // ---------------- configuration C ----------------
    logic [1:0]  c_addr;
    logic        c_rdn, c_wrtn, c_incn, c_clrn;
    logic [23:0] c_out;
    logic [2:0]  c_zero, c_carry;
    logic        c_err;
    logic        c_drv_en;
    logic [7:0]  c_drv;
    tri1  [7:0]  c_bus;
    assign c_bus = c_drv_en ? c_drv : 8'hzz;
    logic [7:0]  mc [3];
    logic [2:0]  mcc;

    bus_regfile #(.DATA_W(8), .NUM_REGS(3)) dut_c (
        .i_clk(clk), .i_rstn(rstn), .io_bus_data(c_bus), .i_addr(c_addr),
        .i_rdn(c_rdn), .i_wrtn(c_wrtn), .i_incn(c_incn), .i_clrn(c_clrn),
        .o_out_data(c_out), .o_zero(c_zero), .o_carry(c_carry), .o_err(c_err)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic err_of(input logic rd, wr, inc, clr, ok);
        logic multi;
        multi = (!wr && !inc) || (!wr && !clr) || (!inc && !clr);
        return (!rd && !wr) || multi || (!ok && !(rd && wr && inc && clr));
    endfunction

    function automatic logic rs();
        return ($urandom_range(0, 2) != 0);
    endfunction

    // Each step: drive at posedge+1, check the bus before the next edge,
    // then check registered state at posedge+1.
    task automatic step_a(input logic [1:0] ad, input logic rd, wr, inc, clr, input logic [7:0] d);
        logic        e;
        logic [31:0] eo;
        logic [3:0]  ez;
        a_addr = ad; a_rdn = rd; a_wrtn = wr; a_incn = inc; a_clrn = clr;
        a_drv = d; a_drv_en = !wr && rd;
        #3;
        if (!rd && wr)      chk("a_read", a_bus, ma[ad]);
        else if (!a_drv_en) chk("a_bus_released", a_bus, 8'hFF);
        e = err_of(rd, wr, inc, clr, 1'b1);
        if (!clr) begin
            ma[ad] = 8'h00; mca[ad] = 1'b0;
        end else if (!wr && rd) begin
            ma[ad] = d; mca[ad] = 1'b0;
        end else if (!inc) begin
            if (ma[ad] == 8'hFF) mca[ad] = 1'b1;
            ma[ad] = ma[ad] + 8'd1;
        end
        @(posedge clk); #1;
        a_drv_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            eo[k*8 +: 8] = ma[k];
            ez[k]        = (ma[k] == 8'h00);
        end
        chk("a_out", a_out, eo);
        chk("a_zero", a_zero, ez);
        chk("a_carry", a_carry, mca);
        chk("a_err", a_err, e);
    endtask

    task automatic step_b(input logic [2:0] ad, input logic rd, wr, inc, clr, input logic [15:0] d);
        logic         e;
        logic [127:0] eo;
        logic [7:0]   ez;
        b_addr = ad; b_rdn = rd; b_wrtn = wr; b_incn = inc; b_clrn = clr;
        b_drv = d; b_drv_en = !wr && rd;
        #3;
        if (!rd && wr)      chk("b_read", b_bus, mb[ad]);
        else if (!b_drv_en) chk("b_bus_released", b_bus, 16'hFFFF);
        e = err_of(rd, wr, inc, clr, 1'b1);
        if (!clr) begin
            mb[ad] = 16'h0000; mcb[ad] = 1'b0;
        end else if (!wr && rd) begin
            mb[ad] = d; mcb[ad] = 1'b0;
        end else if (!inc) begin
            if (mb[ad] == 16'hFFFF) mcb[ad] = 1'b1;
            mb[ad] = mb[ad] + 16'd1;
        end
        @(posedge clk); #1;
        b_drv_en = 1'b0;
        for (int k = 0; k < 8; k++) begin
            eo[k*16 +: 16] = mb[k];
            ez[k]          = (mb[k] == 16'h0000);
        end
        chk("b_out", b_out, eo);
        chk("b_zero", b_zero, ez);
        chk("b_carry", b_carry, mcb);
        chk("b_err", b_err, e);
    endtask

    task automatic step_c(input logic [1:0] ad, input logic rd, wr, inc, clr, input logic [7:0] d);
        logic        e;
        logic        ok;
        logic [23:0] eo;
        ok = (ad != 2'd3);
        c_addr = ad; c_rdn = rd; c_wrtn = wr; c_incn = inc; c_clrn = clr;
        c_drv = d; c_drv_en = !wr && rd;
        #3;
        if (!rd && wr && ok) chk("c_read", c_bus, mc[ad]);
        else if (!c_drv_en)  chk("c_bus_released", c_bus, 8'hFF);
        e = err_of(rd, wr, inc, clr, ok);
        if (ok) begin
            if (!clr) begin
                mc[ad] = 8'h00; mcc[ad] = 1'b0;
            end else if (!wr && rd) begin
                mc[ad] = d; mcc[ad] = 1'b0;
            end else if (!inc) begin
                if (mc[ad] == 8'hFF) mcc[ad] = 1'b1;
                mc[ad] = mc[ad] + 8'd1;
            end
        end
        @(posedge clk); #1;
        c_drv_en = 1'b0;
        for (int k = 0; k < 3; k++) eo[k*8 +: 8] = mc[k];
        chk("c_out", c_out, eo);
        chk("c_carry", c_carry, mcc);
        chk("c_err", c_err, e);
    endtask

    task automatic idle_all();
        a_rdn = 1; a_wrtn = 1; a_incn = 1; a_clrn = 1; a_drv_en = 0; a_addr = 0; a_drv = 0;
        b_rdn = 1; b_wrtn = 1; b_incn = 1; b_clrn = 1; b_drv_en = 0; b_addr = 0; b_drv = 0;
        c_rdn = 1; c_wrtn = 1; c_incn = 1; c_clrn = 1; c_drv_en = 0; c_addr = 0; c_drv = 0;
    endtask

    task automatic clear_models();
        for (int k = 0; k < 4; k++) ma[k] = 8'h00;
        for (int k = 0; k < 8; k++) mb[k] = 16'h0000;
        for (int k = 0; k < 3; k++) mc[k] = 8'h00;
        mca = '0; mcb = '0; mcc = '0;
    endtask

    // Reset pulsed mid-cycle with read strobes active: state must clear
    // before the next clock edge and the buses must stay released.
    task automatic reset_mid();
        idle_all();
        a_rdn = 0; a_addr = 2'd2;
        b_rdn = 0; b_addr = 3'd5;
        c_rdn = 0; c_addr = 2'd1;
        #2;
        rstn = 1'b0;
        #1;
        chk("rst_a_out", a_out, 32'h0);
        chk("rst_a_carry", a_carry, 4'h0);
        chk("rst_a_zero", a_zero, 4'hF);
        chk("rst_a_err", a_err, 1'b0);
        chk("rst_a_bus", a_bus, 8'hFF);
        chk("rst_b_out", b_out, 128'h0);
        chk("rst_b_carry", b_carry, 8'h00);
        chk("rst_b_bus", b_bus, 16'hFFFF);
        chk("rst_c_out", c_out, 24'h0);
        chk("rst_c_bus", c_bus, 8'hFF);
        idle_all();
        #1;
        rstn = 1'b1;
        clear_models();
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_all();
        clear_models();
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;

        chk("init_a_out", a_out, 32'h0);
        chk("init_a_zero", a_zero, 4'hF);
        chk("init_a_carry", a_carry, 4'h0);
        chk("init_a_err", a_err, 1'b0);
        chk("init_a_bus", a_bus, 8'hFF);

        // write then same-cycle read
        step_a(2'd2, 1, 0, 1, 1, 8'hA5);
        step_a(2'd2, 0, 1, 1, 1, 8'h00);
        chk("a_reg2_a5", a_out[23:16], 8'hA5);

        // increment through wrap, then write clears carry
        step_a(2'd1, 1, 0, 1, 1, 8'hFE);
        step_a(2'd1, 1, 1, 0, 1, 8'h00);
        chk("a_reg1_ff", a_out[15:8], 8'hFF);
        step_a(2'd1, 1, 1, 0, 1, 8'h00);
        chk("a_reg1_wrap", {a_out[15:8], a_zero[1], a_carry[1]}, {8'h00, 1'b1, 1'b1});
        step_a(2'd1, 1, 1, 0, 1, 8'h00);
        chk("a_carry1_sticky", a_carry[1], 1'b1);
        step_a(2'd1, 1, 0, 1, 1, 8'h03);
        chk("a_carry1_cleared", a_carry[1], 1'b0);

        // read/write conflict: bus released, no write, err for exactly one cycle
        step_a(2'd0, 1, 0, 1, 1, 8'h5A);
        step_a(2'd0, 0, 0, 1, 1, 8'h77);
        chk("a_conflict_hold", a_out[7:0], 8'h5A);
        step_a(2'd0, 1, 1, 1, 1, 8'h00);
        // conflict with increment: increment still applies
        step_a(2'd0, 0, 0, 0, 1, 8'h00);
        chk("a_conflict_inc", a_out[7:0], 8'h5B);

        // clear wins over write and increment
        step_a(2'd3, 1, 0, 1, 1, 8'h40);
        step_a(2'd3, 1, 0, 0, 0, 8'h12);
        chk("a_clr_prio", a_out[31:24], 8'h00);
        step_a(2'd3, 1, 1, 1, 1, 8'h00);
        // write beats increment
        step_a(2'd2, 1, 0, 0, 1, 8'h33);
        chk("a_wr_over_inc", a_out[23:16], 8'h33);

        // leave carry set and err pending, then async reset mid-cycle
        step_a(2'd0, 1, 0, 1, 1, 8'hFF);
        step_a(2'd0, 1, 1, 0, 1, 8'h00);
        step_a(2'd1, 0, 0, 1, 1, 8'h00);
        reset_mid();

        // out-of-range address on a 3-register bank
        step_c(2'd0, 1, 0, 1, 1, 8'h11);
        step_c(2'd1, 1, 0, 1, 1, 8'h22);
        step_c(2'd2, 1, 0, 1, 1, 8'h33);
        step_c(2'd3, 1, 0, 1, 1, 8'h99);
        step_c(2'd3, 1, 1, 0, 1, 8'h00);
        step_c(2'd3, 1, 1, 1, 0, 8'h00);
        step_c(2'd3, 0, 1, 1, 1, 8'h00);
        step_c(2'd3, 1, 1, 1, 1, 8'h00);
        step_c(2'd2, 0, 1, 1, 1, 8'h00);
        step_c(2'd2, 1, 1, 1, 0, 8'h00);

        // randomised sweeps with a reset in the middle
        for (int i = 0; i < 60; i++) begin
            if (i == 30) reset_mid();
            step_a(2'($urandom_range(0, 3)), rs(), rs(), rs(), rs(), 8'($urandom));
        end
        for (int i = 0; i < 120; i++) begin
            if (i == 60) reset_mid();
            if (i % 10 == 0)
                step_b(3'($urandom_range(0, 7)), 1, 0, 1, 1, 16'hFFFE + 16'($urandom_range(0, 1)));
            else
                step_b(3'($urandom_range(0, 7)), rs(), rs(), rs(), rs(), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
